// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC source encodings, halt opcode and PC-stage state type.
package cpu_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_REG = 2'b11;

  localparam logic [5:0] HALT_OP = 6'b111111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_unit_if.sv
// Control/operand inputs and fetch-address outputs of the PC stage.
interface pc_unit_if;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [5:0]  op;
  logic [15:0] immediate;
  logic [25:0] target;
  logic [31:0] rs_data;
  logic [31:0] InsAddr;
  logic [31:0] PC4;
  logic        halted;
  logic        fault;
  logic [31:0] fault_addr;

  modport master (
    output PCWre, PCSrc, op, immediate, target, rs_data,
    input  InsAddr, PC4, halted, fault, fault_addr
  );

  modport slave (
    input  PCWre, PCSrc, op, immediate, target, rs_data,
    output InsAddr, PC4, halted, fault, fault_addr
  );
endinterface

// File: rtl/next_pc_mux.sv
// Combinational next-PC candidate generation and PCSrc selection.
module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  pc_src_i,
  input  logic [15:0] immediate_i,
  input  logic [25:0] target_i,
  input  logic [31:0] rs_data_i,
  output logic [31:0] seq_o,
  output logic [31:0] next_pc_o
);

  logic [31:0] br;
  logic [31:0] jmp;

  assign seq_o = pc_i + 32'd4;
  assign br    = seq_o + {{14{immediate_i[15]}}, immediate_i, 2'b00};
  assign jmp   = {seq_o[31:28], target_i, 2'b00};

  always_comb begin
    next_pc_o = seq_o;
    unique case (pc_src_i)
      PC_SEQ:  next_pc_o = seq_o;
      PC_BR:   next_pc_o = br;
      PC_JMP:  next_pc_o = jmp;
      PC_REG:  next_pc_o = rs_data_i;
      default: next_pc_o = seq_o;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: next-PC select, halt detection and fetch-address trap.
module pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 256,
  parameter logic [5:0]  HALT_OP    = cpu_pkg::HALT_OP
) (
  input  logic       CLK,
  input  logic       Reset,
  pc_unit_if.slave   bus
);

  localparam logic [31:0] MaxPc = 32'(IMEM_BYTES) - 32'd4;

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] seq;
  logic [31:0] cand;
  logic        illegal;

  next_pc_mux u_next_pc_mux (
    .pc_i        (pc_q),
    .pc_src_i    (bus.PCSrc),
    .immediate_i (bus.immediate),
    .target_i    (bus.target),
    .rs_data_i   (bus.rs_data),
    .seq_o       (seq),
    .next_pc_o   (cand)
  );

  // Full 32-bit unsigned compare: wrapped addresses land above MaxPc and trap.
  assign illegal = (cand[1:0] != 2'b00) || (cand > MaxPc);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    if (state_q == RUN && bus.PCWre) begin
      if (bus.op == HALT_OP) begin
        state_d = HALT;
      end else if (illegal) begin
        state_d      = FAULT;
        fault_addr_d = cand;
      end else begin
        pc_d = cand;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign bus.InsAddr    = pc_q;
  assign bus.PC4        = seq;
  assign bus.halted     = (state_q == HALT);
  assign bus.fault      = (state_q == FAULT);
  assign bus.fault_addr = fault_addr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed test-plan steps followed by random traffic.
module tb_pc_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_BYTES = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state: 0 = running, 1 = halted, 2 = faulted.
  logic [31:0] m_pc;
  int          m_st;
  logic [31:0] m_fa;

  pc_unit_if bus ();

  pc_unit #(
    .RESET_PC   (RESET_PC),
    .IMEM_BYTES (IMEM_BYTES),
    .HALT_OP    (6'b111111)
  ) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit we, input logic [1:0] src,
                            input logic [5:0] o, input logic [15:0] imm,
                            input logic [25:0] tgt, input logic [31:0] rs);
    logic [31:0] seq;
    logic [31:0] cand;
    if (r) begin
      m_pc = RESET_PC;
      m_st = 0;
      m_fa = 32'd0;
      return;
    end
    if (m_st != 0 || !we) return;
    seq = m_pc + 32'd4;
    case (src)
      2'd0:    cand = seq;
      2'd1:    cand = seq + 32'(int'($signed(imm)) * 4);
      2'd2:    cand = (seq / 32'h1000_0000) * 32'h1000_0000 + 32'(tgt) * 32'd4;
      default: cand = rs;
    endcase
    if (o == 6'd63) begin
      m_st = 1;
    end else if ((cand % 32'd4) != 32'd0 || cand > 32'(IMEM_BYTES) - 32'd4) begin
      m_st = 2;
      m_fa = cand;
    end else begin
      m_pc = cand;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".InsAddr"},    bus.InsAddr,    m_pc);
    check({tag, ".PC4"},        bus.PC4,        m_pc + 32'd4);
    check({tag, ".halted"},     {31'd0, bus.halted}, (m_st == 1) ? 32'd1 : 32'd0);
    check({tag, ".fault"},      {31'd0, bus.fault},  (m_st == 2) ? 32'd1 : 32'd0);
    check({tag, ".fault_addr"}, bus.fault_addr, m_fa);
  endtask

  task automatic step(input string tag, input bit r, input bit we, input logic [1:0] src,
                      input logic [5:0] o, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic [31:0] rs);
    rst           = r;
    bus.PCWre     = we;
    bus.PCSrc     = src;
    bus.op        = o;
    bus.immediate = imm;
    bus.target    = tgt;
    bus.rs_data   = rs;
    model_step(r, we, src, o, imm, tgt, rs);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    m_pc = RESET_PC;
    m_st = 0;
    m_fa = 32'd0;

    // Reset wins over a simultaneous halt opcode with PCWre=1.
    step("reset", 1, 1, 2'b00, 6'h3F, 16'h0, 26'h0, 32'h0);
    check("reset_pc", bus.InsAddr, 32'h0);
    step("seq1", 0, 1, 2'b00, 6'h00, 16'h0, 26'h0, 32'h0);
    step("seq2", 0, 1, 2'b00, 6'h00, 16'h0, 26'h0, 32'h0);
    step("seq3", 0, 1, 2'b00, 6'h00, 16'h0, 26'h0, 32'h0);
    check("seq3_pc", bus.InsAddr, 32'hC);
    check("seq3_pc4", bus.PC4, 32'h10);

    step("reset2", 1, 0, 2'b00, 6'h00, 16'h0, 26'h0, 32'h0);
    step("seq_a", 0, 1, 2'b00, 6'h00, 16'h0, 26'h0, 32'h0);
    step("seq_b", 0, 1, 2'b00, 6'h00, 16'h0, 26'h0, 32'h0);
    step("br_back", 0, 1, 2'b01, 6'h00, 16'hFFFE, 26'h0, 32'h0);
    check("br_back_pc", bus.InsAddr, 32'h4);
    step("br_fwd", 0, 1, 2'b01, 6'h00, 16'h0003, 26'h0, 32'h0);
    check("br_fwd_pc", bus.InsAddr, 32'h14);
    step("jmp", 0, 1, 2'b10, 6'h00, 16'h0, 26'h0000010, 32'h0);
    check("jmp_pc", bus.InsAddr, 32'h40);
    step("jr", 0, 1, 2'b11, 6'h00, 16'h0, 26'h0, 32'h80);
    check("jr_pc", bus.InsAddr, 32'h80);
    step("jr_mis", 0, 1, 2'b11, 6'h00, 16'h0, 26'h0, 32'h82);
    check("mis_fault", {31'd0, bus.fault}, 32'd1);
    check("mis_addr", bus.fault_addr, 32'h82);
    check("mis_hold", bus.InsAddr, 32'h80);
    step("fault_abs", 0, 1, 2'b00, 6'h3F, 16'h0, 26'h0, 32'h0);

    step("reset3", 1, 0, 2'b00, 6'h00, 16'h0, 26'h0, 32'h0);
    step("jr_oor", 0, 1, 2'b11, 6'h00, 16'h0, 26'h0, 32'h100);
    check("oor_addr", bus.fault_addr, 32'h100);
    step("reset4", 1, 0, 2'b00, 6'h00, 16'h0, 26'h0, 32'h0);
    step("br_wrap", 0, 1, 2'b01, 6'h00, 16'hFFFD, 26'h0, 32'h0);
    check("wrap_addr", bus.fault_addr, 32'hFFFF_FFF8);

    step("reset5", 1, 0, 2'b00, 6'h00, 16'h0, 26'h0, 32'h0);
    step("jr20", 0, 1, 2'b11, 6'h00, 16'h0, 26'h0, 32'h20);
    step("halt", 0, 1, 2'b11, 6'h3F, 16'h0, 26'h0, 32'h3);
    check("halt_flag", {31'd0, bus.halted}, 32'd1);
    check("halt_nofault", {31'd0, bus.fault}, 32'd0);
    for (int i = 0; i < 5; i++) step("halt_hold", 0, 1, 2'b00, 6'h00, 16'h0, 26'h0, 32'h0);
    check("halt_pc", bus.InsAddr, 32'h20);
    for (int i = 0; i < 4; i++) step("we0_hold", 0, 0, 2'b01, 6'h00, 16'h1, 26'h0, 32'h0);
    step("halt_reset", 1, 1, 2'b00, 6'h00, 16'h0, 26'h0, 32'h0);
    check("halt_reset_flag", {31'd0, bus.halted}, 32'd0);

    // PCWre=0 in RUN must skip both halt and fault checks.
    step("we0_run", 0, 0, 2'b11, 6'h3F, 16'h0, 26'h0, 32'h3);

    for (int i = 0; i < 400; i++) begin
      bit          r;
      bit          we;
      logic [5:0]  o;
      logic [31:0] rs;
      logic [15:0] imm;
      r   = ($urandom_range(0, 14) == 0);
      we  = ($urandom_range(0, 4) != 0);
      o   = ($urandom_range(0, 19) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
      rs  = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 63)) * 32'd4;
      imm = 16'(int'($urandom_range(0, 40)) - 20);
      step("rand", r, we, 2'($urandom_range(0, 3)), o, imm, 26'($urandom_range(0, 70)), rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
